mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Shares the single DPI-backed memory port (MemContrl-style valid/wen/raddr/waddr/wdata/wmask/rdata) between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Handles one outstanding transaction at a time, arbitrated round-robin.
- Sequences the memory access with a programmable wait latency and returns the response to the owning requester through a valid/ready handshake.
- Sits between IFU/LSU and the memory model in the NPC top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 1, number of WAIT cycles mem_valid is held per read (≥1; values <1 are illegal).

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_req_addr in ADDR_W: fetch request channel.
- ifu_resp_valid out 1 / ifu_resp_ready in 1 / ifu_resp_data out DATA_W: fetch response channel.
- lsu_req_valid in 1 / lsu_req_ready out 1: LSU request handshake.
- lsu_req_wen in 1: 1 = write, 0 = read.
- lsu_req_addr in ADDR_W / lsu_req_wdata in DATA_W / lsu_req_wmask in 8: LSU request payload.
- lsu_resp_valid out 1 / lsu_resp_ready in 1 / lsu_resp_data out DATA_W: LSU response channel (write ack carries data 0).
- mem_valid out 1 / mem_wen out 1: memory port strobes.
- mem_raddr out ADDR_W / mem_waddr out ADDR_W: both driven from the latched address.
- mem_wdata out DATA_W / mem_wmask out 8: memory write payload.
- mem_rdata in DATA_W: memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0, last_grant=IFU.
  - All outputs 0, all latched request registers 0.
  - Takes effect immediately, including mid-transaction.
  - An in-flight transaction is dropped and produces no response.
  - mem_valid falls without waiting for a clock edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ifu_req_ready = ifu_req_valid & (~lsu_req_valid | last_grant==LSU).
  - lsu_req_ready = lsu_req_valid & (~ifu_req_valid | last_grant==IFU).
  - At most one ready is high. Ready never rises without the matching valid, and is 0 outside IDLE.
  - On handshake:
    - latch owner, addr, wen (IFU: 0), wdata, wmask (IFU: 0);
    - set last_grant=owner, counter=LATENCY-1;
    - go to WAIT.
- Round-robin: if both request in the same IDLE cycle, grant the one not granted last. After reset, the LSU wins the first tie.
- WAIT:
  - mem_raddr = mem_waddr = latched addr; mem_wdata/mem_wmask = latched values.
  - Read: mem_valid=1, mem_wen=0 for all LATENCY cycles. mem_rdata is sampled into the response register on the last WAIT cycle (counter==0).
  - Write: mem_valid=1, mem_wen=1 on the first WAIT cycle only, so the memory model performs exactly one write. mem_valid=0 for the remaining cycles. Response data = 0.
  - Counter decrements each cycle. At counter==0, go to RESP.
- RESP:
  - Owner's resp_valid=1 with the captured data; the non-owner resp_valid stays 0.
  - resp_data is held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready, go to IDLE. The next request can handshake in the following cycle (no IDLE bypass).
- Outside WAIT: mem_valid=0, mem_wen=0. Address and data outputs hold their last latched values.
- Timing: request handshake at edge N; WAIT spans cycles N+1..N+LATENCY; resp_valid is first high in cycle N+LATENCY+1. Minimum occupancy is LATENCY+2 cycles per transaction.
- A requester may drop valid before ready. Requests not accepted are never latched.
- resp_ready high while not in RESP has no effect.

Test Plan:
- IFU read, LATENCY=1, addr 0x80000000, memory holds 0x00000413 → ifu_req_ready same cycle; mem_valid=1 for exactly 1 cycle with mem_raddr 0x80000000; ifu_resp_valid 2 cycles after accept with data 0x00000413; lsu_resp_valid stays 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, LATENCY=3 → mem_wen=1 on exactly one cycle; lsu_resp_valid at accept+4 with data 0. A following LSU read of 0x80001000 returns 0xDEADBEEF.
- IFU and LSU valid continuously for 4 transactions, both reads → grant order LSU, IFU, LSU, IFU; never two readies in one cycle.
- ifu_resp_ready held 0 for 5 cycles in RESP while lsu_req_valid=1 → ifu_resp_valid and data stable; lsu_req_ready stays 0; LSU is granted the cycle after the IFU response handshake.
- rst_n pulled low mid-WAIT of an LSU write at LATENCY=3 → mem_valid and all resp_valid drop immediately, no response is ever issued, and after release the first tie is granted to the LSU.
- LATENCY=3 read, mem_rdata changes 0x1→0x2→0x3 over the WAIT cycles → response data 0x3 (last-cycle sample).

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU.
// One transaction in flight: IDLE handshake -> LATENCY WAIT cycles -> RESP handshake.
module mem_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_wen,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [7:0]        lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {GRANT_IFU, GRANT_LSU} grant_t;

  state_t            state, state_nxt;
  grant_t            last_grant, owner;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ifu_grant, lsu_grant, resp_fire, first_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ifu_grant      = 1'b0;
    lsu_grant      = 1'b0;
    resp_fire      = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_valid      = 1'b0;
    mem_wen        = 1'b0;
    first_wait     = (cnt == CNT_INIT);
    case (state)
      IDLE: begin
        // Tie goes to whoever was not granted last
        ifu_grant = ifu_req_valid && (!lsu_req_valid || last_grant == GRANT_LSU);
        lsu_grant = lsu_req_valid && (!ifu_req_valid || last_grant == GRANT_IFU);
        if (ifu_grant || lsu_grant) state_nxt = WAIT;
      end
      WAIT: begin
        // Writes strobe only the first cycle so the model writes exactly once
        mem_valid = !wen_q || first_wait;
        mem_wen   = wen_q && first_wait;
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        ifu_resp_valid = (owner == GRANT_IFU);
        lsu_resp_valid = (owner == GRANT_LSU);
        resp_fire = (owner == GRANT_IFU) ? ifu_resp_ready : lsu_resp_ready;
        if (resp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifu_req_ready = ifu_grant;
  assign lsu_req_ready = lsu_grant;
  assign ifu_resp_data = rdata_q;
  assign lsu_resp_data = rdata_q;
  assign mem_raddr     = addr_q;
  assign mem_waddr     = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_IFU;
      owner      <= GRANT_IFU;
      cnt        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_grant) begin
            owner      <= GRANT_IFU;
            last_grant <= GRANT_IFU;
            addr_q     <= ifu_req_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt        <= CNT_INIT;
          end else if (lsu_grant) begin
            owner      <= GRANT_LSU;
            last_grant <= GRANT_LSU;
            addr_q     <= lsu_req_addr;
            wen_q      <= lsu_req_wen;
            wdata_q    <= lsu_req_wdata;
            wmask_q    <= lsu_req_wmask;
            cnt        <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) rdata_q <= wen_q ? '0 : mem_rdata;
          else           cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
